// File: rtl/mem_map_pkg.sv
// Memory map shared by the data-side responder and its TX FIFO.
// Holds the default MMIO bank base, MMIO register offsets (DataAdr[7:0])
// and the bit positions of the STATUS register.
package mem_map_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

   localparam logic [7:0] OFF_LED    = 8'h00;
   localparam logic [7:0] OFF_SW     = 8'h04;
   localparam logic [7:0] OFF_CYCLE  = 8'h08;
   localparam logic [7:0] OFF_TXDATA = 8'h0C;
   localparam logic [7:0] OFF_STATUS = 8'h10;

   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVF       = 2;
   localparam int unsigned ST_COUNT_LSB = 4;
   localparam int unsigned ST_COUNT_W   = 4;

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// tx_fifo: 8-bit transmit FIFO with sticky overflow flag.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, din        write strobe and byte
//   pop              consumer takes the head (ignored while empty)
//   dout             head byte, 0 while empty
//   empty, full      occupancy flags
//   count            number of stored entries
//   overflow         sticky: set by a push dropped on a full FIFO
//   clr_ovf          clears overflow
module tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [7:0]             din,
   input  logic                   pop,
   output logic [7:0]             dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   clr_ovf
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic          r_ovf;

   logic w_pop;
   logic w_push;
   logic w_drop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == FULL_CNT);
   assign count    = r_count;
   assign overflow = r_ovf;
   assign dout     = empty ? 8'h00 : r_mem[r_rptr];

   assign w_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push = push & (~full | w_pop);
   assign w_drop = push & full & ~w_pop;

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (clr_ovf)     r_ovf <= 1'b0;
         else if (w_drop) r_ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side responder for the single-cycle core.
// Serves a word-addressed RAM at the bottom of the address space and an
// MMIO bank (LED, SW, CYCLE, TXDATA, STATUS) at MMIO_BASE. Loads are
// combinational; all state changes on the rising clock edge.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   MemWrite             store strobe
//   DataAdr, WriteData   byte address and store data
//   ReadData             load data, combinational from DataAdr
//   led                  LED register
//   sw                   switch inputs
//   tx_valid, tx_data    TX FIFO head (registered state only)
//   tx_ready             consumer accepts the head this cycle
module dmem_mmio
   import mem_map_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  led,
   input  logic [7:0]  sw,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0] r_ram [RAM_WORDS];
   logic [7:0]  r_led;
   logic [31:0] r_cycle;

   logic          w_ram_hit;
   logic          w_mmio_hit;
   logic [7:0]    w_off;
   logic [AW-1:0] w_idx;
   logic          w_wr_led;
   logic          w_wr_cycle;
   logic          w_wr_tx;
   logic          w_wr_status;
   logic          w_empty;
   logic          w_full;
   logic          w_ovf;
   logic [CW-1:0] w_count;
   logic [31:0]   w_status;

   assign w_ram_hit  = (DataAdr < 32'(4 * RAM_WORDS));
   assign w_mmio_hit = (DataAdr[31:8] == MMIO_BASE[31:8]);
   // Byte lane bits are ignored: every access is a word access.
   assign w_off      = {DataAdr[7:2], 2'b00};
   assign w_idx      = DataAdr[AW+1:2];

   assign w_wr_led    = MemWrite & w_mmio_hit & (w_off == OFF_LED);
   assign w_wr_cycle  = MemWrite & w_mmio_hit & (w_off == OFF_CYCLE);
   assign w_wr_tx     = MemWrite & w_mmio_hit & (w_off == OFF_TXDATA);
   assign w_wr_status = MemWrite & w_mmio_hit & (w_off == OFF_STATUS);

   assign led      = r_led;
   assign tx_valid = ~w_empty;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (w_wr_tx),
      .din      (WriteData[7:0]),
      .pop      (tx_valid & tx_ready),
      .dout     (tx_data),
      .empty    (w_empty),
      .full     (w_full),
      .count    (w_count),
      .overflow (w_ovf),
      .clr_ovf  (w_wr_status)
   );

   // RAM is not reset, but a store coinciding with reset is still suppressed.
   always_ff @(posedge clk) begin
      if (MemWrite & w_ram_hit & ~reset) r_ram[w_idx] <= WriteData;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_led   <= 8'h00;
         r_cycle <= 32'h0;
      end else begin
         if (w_wr_led) r_led <= WriteData[7:0];
         if (w_wr_cycle) r_cycle <= WriteData;
         else            r_cycle <= r_cycle + 32'd1;
      end
   end

   always_comb begin
      w_status = 32'h0;
      w_status[ST_EMPTY] = w_empty;
      w_status[ST_FULL]  = w_full;
      w_status[ST_OVF]   = w_ovf;
      w_status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_count);
   end

   always_comb begin
      ReadData = 32'h0;
      if (w_ram_hit) begin
         ReadData = r_ram[w_idx];
      end else if (w_mmio_hit) begin
         case (w_off)
            OFF_LED:    ReadData = {24'h0, r_led};
            OFF_SW:     ReadData = {24'h0, sw};
            OFF_CYCLE:  ReadData = r_cycle;
            OFF_STATUS: ReadData = w_status;
            default:    ReadData = 32'h0;
         endcase
      end
   end

endmodule
